// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the ID/EX pipeline sequencer
// Contents: ctrl_state_e {ST_RUN, ST_MCBUSY}, REG_ZERO, OP_NOP, MC_CNT_W, reg_match().
package cpu_ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MCBUSY = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [5:0] OP_NOP   = 6'd0;

    // Wide enough for MC_LATENCY-2 with MC_LATENCY up to 15.
    localparam int MC_CNT_W = 4;

    // A producer only conflicts with a reader when it targets a real register.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/idex_mc_timer.sv
// rtl/idex_mc_timer.sv - loadable down-counter that times the multi-cycle EX hold
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load value into the counter
//   value       remaining MCBUSY cycles after the start cycle
//   en          count down (one step per cycle while busy)
//   done        current cycle is the last busy cycle
module idex_mc_timer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MC_CNT_W-1:0] value,
    input  logic                en,
    output logic                done
);

    logic [MC_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // The last busy cycle is the one whose decrement reaches zero. A load of
    // zero still gives one busy cycle, because the start cycle always enters MCBUSY.
    assign done = (count <= MC_CNT_W'(1));

endmodule

// File: rtl/idex_hazard_ctrl.sv
// rtl/idex_hazard_ctrl.sv - ID/EX hazard, multi-cycle hold and branch squash sequencer
// Config macro: IDEX_FORWARDING_EN (defined: load-use stalls only; undefined: stall on any
//   EX/MEM producer until it retires).
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   id_valid/id_rs/id_rt/id_uses_rt   ID instruction and its source registers
//   ex_valid/ex_rd/ex_reg_write/ex_mem_read/ex_mc_start/ex_branch_taken  EX status
//   mem_rd/mem_reg_write              MEM producer
//   pc_hold/ifid_hold/ifid_flush/idex_hold/idex_flush  pipeline register controls
//   ex_busy                           multi-cycle op in progress
//   stall_cycles                      saturating count of cycles with pc_hold=1
module idex_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mc_start,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             ex_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    ctrl_state_e state, state_next;
    logic        hazard;
    logic        mc_load;
    logic        mc_done;

`ifdef IDEX_FORWARDING_EN
    // Forwarding covers ALU results; only a load's data arrives too late for ID.
    assign hazard = id_valid && ex_valid && ex_mem_read &&
                    (reg_match(ex_rd, id_rs) || (id_uses_rt && reg_match(ex_rd, id_rt)));

    logic unused_fwd;
    assign unused_fwd = &{1'b0, ex_reg_write, mem_rd, mem_reg_write};
`else
    logic ex_hit, mem_hit;

    // Without forwarding ID must wait until the producer has written back.
    assign ex_hit  = ex_valid && ex_reg_write &&
                     (reg_match(ex_rd, id_rs) || (id_uses_rt && reg_match(ex_rd, id_rt)));
    assign mem_hit = mem_reg_write &&
                     (reg_match(mem_rd, id_rs) || (id_uses_rt && reg_match(mem_rd, id_rt)));
    assign hazard  = id_valid && (ex_hit || mem_hit);

    logic unused_nofwd;
    assign unused_nofwd = &{1'b0, ex_mem_read};
`endif

    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        ex_busy    = 1'b0;
        mc_load    = 1'b0;
        state_next = state;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Branch wins even over a (malformed) simultaneous mc start.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_mc_start) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_hold  = 1'b1;
                        ex_busy    = 1'b1;
                        mc_load    = 1'b1;
                        state_next = ST_MCBUSY;
                    end else if (hazard) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_MCBUSY: begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    idex_hold = 1'b1;
                    ex_busy   = 1'b1;
                    if (mc_done) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_hold && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    idex_mc_timer u_mc_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (mc_load),
        .value (MC_CNT_W'(MC_LATENCY - 2)),
        .en    (state == ST_MCBUSY),
        .done  (mc_done)
    );

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb/tb_idex_hazard_ctrl.sv - scoreboard bench for idex_hazard_ctrl
module tb_idex_hazard_ctrl;

    localparam int MC_LATENCY = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_uses_rt;
    logic [4:0]       id_rs, id_rt;
    logic             ex_valid, ex_reg_write, ex_mem_read, ex_mc_start, ex_branch_taken;
    logic [4:0]       ex_rd, mem_rd;
    logic             mem_reg_write;
    logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, ex_busy;
    logic [CNT_W-1:0] stall_cycles;

    idex_hazard_ctrl #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mc_start     (ex_mc_start),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_hold       (idex_hold),
        .idex_flush      (idex_flush),
        .ex_busy         (ex_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] ctrl;
        logic [3:0] stall;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Bench model: remaining MCBUSY cycles and the expected stall count.
    int         m_busy_left = 0;
    logic [3:0] m_stall     = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic logic model_hazard(
        input logic idv, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
        input logic exv, input logic [4:0] exrd, input logic exrw, input logic exmr,
        input logic [4:0] memrd, input logic memrw);
`ifdef IDEX_FORWARDING_EN
        return idv && exv && exmr && (hit(exrd, rs) || (urt && hit(exrd, rt)));
`else
        logic ex_p, mem_p;
        ex_p  = exv && exrw && (hit(exrd, rs) || (urt && hit(exrd, rt)));
        mem_p = memrw && (hit(memrd, rs) || (urt && hit(memrd, rt)));
        return idv && (ex_p || mem_p);
`endif
    endfunction

    // Order: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, ex_busy}
    localparam logic [5:0] E_IDLE = 6'b000000;
    localparam logic [5:0] E_MC   = 6'b110101;
    localparam logic [5:0] E_BR   = 6'b001010;
    localparam logic [5:0] E_HAZ  = 6'b110010;

    task automatic step(input string tag, input logic r,
                        input logic idv, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic exv, input logic [4:0] exrd, input logic exrw, input logic exmr,
                        input logic exmc, input logic exbr,
                        input logic [4:0] memrd, input logic memrw);
        exp_t e;
        rst = r; id_valid = idv; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_valid = exv; ex_rd = exrd; ex_reg_write = exrw; ex_mem_read = exmr;
        ex_mc_start = exmc; ex_branch_taken = exbr; mem_rd = memrd; mem_reg_write = memrw;
        e.tag  = tag;
        e.ctrl = E_IDLE;
        if (r) begin
            m_busy_left = 0;
            m_stall     = '0;
        end else if (m_busy_left > 0) begin
            e.ctrl = E_MC;
            m_busy_left--;
        end else if (exbr) begin
            e.ctrl = E_BR;
        end else if (exmc) begin
            e.ctrl = E_MC;
            m_busy_left = (MC_LATENCY - 2 < 1) ? 1 : MC_LATENCY - 2;
        end else if (model_hazard(idv, rs, rt, urt, exv, exrd, exrw, exmr, memrd, memrw)) begin
            e.ctrl = E_HAZ;
        end
        e.stall = m_stall;
        sb.push_back(e);
        if (!r && e.ctrl[5] && (m_stall != 4'hF)) m_stall++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check({x.tag, "_ctrl"},
                  {26'd0, pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, ex_busy},
                  {26'd0, x.ctrl});
            check({x.tag, "_stall"}, {28'd0, stall_cycles}, {28'd0, x.stall});
        end
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_valid = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_mc_start = 0; ex_branch_taken = 0; mem_rd = 0; mem_reg_write = 0;
        @(posedge clk);
        #1;
        //       tag          rst idv rs    rt    urt exv exrd  rw mr mc br memrd memrw
        step("rst0",      1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        step("rst1",      1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        step("idle",      0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // ALU producer in EX then MEM, consumer reading rt
        step("raw_ex",    0, 1, 5'd3, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 5'd0, 0);
        step("raw_mem",   0, 1, 5'd3, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, 5'd7, 1);
        step("raw_clr",   0, 1, 5'd3, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        step("rd0",       0, 1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 5'd0, 1);
        step("rt_unused", 0, 1, 5'd3, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, 5'd7, 1);
        step("id_inval",  0, 0, 5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 5'd7, 1);
        // load-use on rs, then the bubble sits in EX while the load is in MEM
        step("lduse",     0, 1, 5'd5, 5'd2, 0, 1, 5'd5, 1, 1, 0, 0, 5'd0, 0);
        step("lduse_mem", 0, 1, 5'd5, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 5'd5, 1);
        step("lduse_clr", 0, 1, 5'd5, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // multi-cycle op; branch/start during MCBUSY must be ignored
        step("mc_start",  0, 1, 5'd9, 5'd1, 1, 1, 5'd9, 1, 0, 1, 0, 5'd0, 0);
        step("mc_b1",     0, 1, 5'd9, 5'd1, 1, 1, 5'd9, 1, 0, 1, 1, 5'd0, 0);
        step("mc_b2",     0, 1, 5'd1, 5'd1, 1, 1, 5'd9, 1, 0, 0, 1, 5'd0, 0);
        step("mc_done",   0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // branch squashes even with a load-use hazard present
        step("br_haz",    0, 1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 1, 5'd0, 0);
        step("br_mc",     0, 1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 1, 1, 5'd0, 0);
        step("post_br",   0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // reset in the middle of MCBUSY
        step("mc2_start", 0, 0, 5'd0, 5'd0, 0, 1, 5'd4, 1, 0, 1, 0, 5'd0, 0);
        step("mc2_rst",   1, 0, 5'd0, 5'd0, 0, 1, 5'd4, 1, 0, 0, 0, 5'd0, 0);
        step("rst_rel",   0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        step("rst_idle",  0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // long load-use stall drives the narrow counter into saturation
        for (int i = 0; i < 20; i++) begin
            step("sat",   0, 1, 5'd3, 5'd6, 1, 1, 5'd6, 1, 1, 0, 0, 5'd0, 0);
        end
        check("sat_final", {28'd0, stall_cycles}, 32'd15);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
